// File: rtl/jk_pkg.sv
// ============================================================================
// Module      : jk_pkg
// Description : Shared op encodings, FSM states and default widths for the
//               JK excitation driver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package jk_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_TOG  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/jk_excite.sv
// ============================================================================
// Module      : jk_excite
// Description : Combinational JK excitation table: cur/tgt -> per-bit J/K.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_cur,
  input  logic [WIDTH-1:0] i_tgt,
  input  logic             i_tog_mode,
  input  logic [WIDTH-1:0] i_mask,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  always_comb begin
    o_j = '0;
    o_k = '0;
    if (i_tog_mode) begin
      // J=K=1 drives the flop's own toggle mode on every masked bit
      o_j = i_mask;
      o_k = i_mask;
    end else begin
      o_j = i_tgt & ~i_cur;
      o_k = i_cur & ~i_tgt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_excite_driver.sv
// ============================================================================
// Module      : jk_excite_driver
// Description : Turns LOAD/SET/CLR/TOG requests into one-cycle J/K pulses for a
//               JK flop bank, mirrors its state and checks q feedback.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] expected,
  output logic             done,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] r_target;
  logic [ERR_W-1:0] r_err;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_tog;
  logic             w_mismatch;

  always_comb begin
    w_target = r_expected;
    case (op_e'(req_op))
      OP_LOAD: w_target = req_data;
      OP_SET:  w_target = r_expected | req_data;
      OP_CLR:  w_target = r_expected & ~req_data;
      OP_TOG:  w_target = r_expected ^ req_data;
      default: w_target = r_expected;
    endcase
  end

  assign w_tog = (op_e'(req_op) == OP_TOG);

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .i_cur      (r_expected),
    .i_tgt      (w_target),
    .i_tog_mode (w_tog),
    .i_mask     (req_data),
    .o_j        (w_j),
    .o_k        (w_k)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_next = DRIVE;
      DRIVE:   w_next = CHECK;
      CHECK:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  assign w_mismatch = (r_state == CHECK) && (q_fb != r_expected);

  // Excitation is computed at acceptance so j/k are registered during DRIVE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_j        <= '0;
      r_k        <= '0;
      r_expected <= '0;
      r_target   <= '0;
      r_err      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_target <= w_target;
            r_j      <= w_j;
            r_k      <= w_k;
          end
        end
        DRIVE: begin
          r_j        <= '0;
          r_k        <= '0;
          r_expected <= r_target;
        end
        CHECK: begin
          if (w_mismatch) begin
            r_expected <= q_fb;
            if (r_err != {ERR_W{1'b1}}) r_err <= r_err + ERR_W'(1);
          end
        end
        default: begin
          r_j <= '0;
          r_k <= '0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign done      = (r_state == CHECK);
  assign mismatch  = w_mismatch;
  assign j         = r_j;
  assign k         = r_k;
  assign expected  = r_expected;
  assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_jk_excite_driver.sv
// ============================================================================
// Module      : tb_jk_excite_driver
// Description : Self-checking bench with a behavioural JK flop bank and a
//               request-level reference model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_jk_excite_driver;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic [7:0] j;
  logic [7:0] k;
  logic [7:0] q_fb;
  logic [7:0] expected;
  logic       done;
  logic       mismatch;
  logic [7:0] err_count;

  logic       rst_n;
  logic [7:0] bank_q;
  logic [7:0] stuck;

  int         n_cmp;
  int         n_bad;
  logic [7:0] m_exp;
  logic [7:0] m_err;

  jk_excite_driver #(
    .WIDTH (8),
    .ERR_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .j         (j),
    .k         (k),
    .q_fb      (q_fb),
    .expected  (expected),
    .done      (done),
    .mismatch  (mismatch),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flop bank; a stuck bit is held at 0 whatever J/K say
  assign rst_n = ~rst;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_n)        bank_q[i] <= 1'b0;
      else if (stuck[i]) bank_q[i] <= 1'b0;
      else begin
        case ({j[i], k[i]})
          2'b01:   bank_q[i] <= 1'b0;
          2'b10:   bank_q[i] <= 1'b1;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end
  assign q_fb = bank_q;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [7:0] d);
    logic [7:0] tgt, ej, ek, qres;
    logic       emis;
    int         waited;
    waited = 0;
    while (!req_ready && waited < 10) begin
      step();
      waited++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    case (op)
      2'd0:    tgt = d;
      2'd1:    tgt = m_exp | d;
      2'd2:    tgt = m_exp & ~d;
      default: tgt = m_exp ^ d;
    endcase
    if (op == 2'd3) begin
      ej = d;
      ek = d;
    end else begin
      ej = tgt & ~m_exp;
      ek = m_exp & ~tgt;
    end
    qres = tgt & ~stuck;
    emis = (qres != tgt);

    req_valid = 1'b1; req_op = op; req_data = d;
    step();
    req_valid = 1'b0; req_data = 8'($urandom);
    n_cmp += 3;
    if (j !== ej) begin n_bad++; $display("FAIL drive_j: got %h required %h", j, ej); end
    if (k !== ek) begin n_bad++; $display("FAIL drive_k: got %h required %h", k, ek); end
    if (req_ready !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL drive_flags: ready=%b done=%b required 0 0", req_ready, done);
    end

    step();
    n_cmp += 4;
    if (done !== 1'b1) begin n_bad++; $display("FAIL check_done: got %b required 1", done); end
    if (mismatch !== emis) begin n_bad++; $display("FAIL check_mismatch: got %b required %b", mismatch, emis); end
    if (expected !== tgt) begin n_bad++; $display("FAIL check_expected: got %h required %h", expected, tgt); end
    if (j !== 8'h00 || k !== 8'h00) begin
      n_bad++; $display("FAIL check_jk_idle: j=%h k=%h required 00 00", j, k);
    end
    if (emis) m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
    m_exp = qres;

    step();
    n_cmp += 3;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL after_flags: ready=%b done=%b required 1 0", req_ready, done);
    end
    if (expected !== m_exp) begin n_bad++; $display("FAIL after_expected: got %h required %h", expected, m_exp); end
    if (err_count !== m_err) begin n_bad++; $display("FAIL after_err: got %0d required %0d", err_count, m_err); end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_data = 8'h00; stuck = 8'h00;
    step();
    step();
    rst = 1'b0;
    m_exp = 8'h00; m_err = 8'h00;
    n_cmp += 4;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    if (j !== 8'h00 || k !== 8'h00) begin n_bad++; $display("FAIL reset_jk: j=%h k=%h required 00 00", j, k); end
    if (expected !== 8'h00 || err_count !== 8'h00) begin
      n_bad++; $display("FAIL reset_state: expected=%h err=%0d required 00 0", expected, err_count);
    end
    if (done !== 1'b0 || mismatch !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: done=%b mismatch=%b required 0 0", done, mismatch);
    end
  endtask

  task automatic test_directed;
    do_req(2'd0, 8'hA5);
    do_req(2'd1, 8'h0F);
    do_req(2'd2, 8'h81);
    do_req(2'd3, 8'hFF);
    n_cmp++;
    if (expected !== 8'hD1) begin n_bad++; $display("FAIL directed_final: got %h required d1", expected); end
  endtask

  task automatic test_zero_mask;
    do_req(2'd1, 8'h00);
    do_req(2'd2, 8'h00);
    do_req(2'd3, 8'h00);
  endtask

  task automatic test_stuck;
    stuck = 8'h01;
    do_req(2'd0, 8'h01);
    stuck = 8'h00;
    n_cmp++;
    if (err_count !== 8'd1 || expected !== 8'h00) begin
      n_bad++; $display("FAIL stuck_result: err=%0d expected=%h required 1 00", err_count, expected);
    end
  endtask

  task automatic test_back_to_back;
    int n_ready, n_done;
    n_ready = 0; n_done = 0;
    req_valid = 1'b1; req_op = 2'd0; req_data = 8'h3C;
    for (int c = 0; c < 30; c++) begin
      step();
      if (req_ready === 1'b1) n_ready++;
      if (done === 1'b1) n_done++;
    end
    req_valid = 1'b0;
    m_exp = 8'h3C;
    n_cmp += 2;
    if (n_ready != 10 || n_done != 10) begin
      n_bad++; $display("FAIL b2b_rate: ready=%0d done=%0d required 10 10", n_ready, n_done);
    end
    if (expected !== 8'h3C) begin n_bad++; $display("FAIL b2b_expected: got %h required 3c", expected); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      stuck = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      do_req(2'($urandom_range(0, 3)), 8'($urandom));
    end
    stuck = 8'h00;
  endtask

  task automatic test_saturation;
    stuck = 8'h01;
    for (int n = 0; n < 260; n++) do_req(2'd0, 8'h01);
    stuck = 8'h00;
    n_cmp++;
    if (err_count !== 8'hFF) begin n_bad++; $display("FAIL saturate: got %0d required 255", err_count); end
  endtask

  task automatic test_reset_mid_drive;
    req_valid = 1'b1; req_op = 2'd0; req_data = 8'hFF;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL mid_enter_drive: ready=%b required 0", req_ready); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_exp = 8'h00; m_err = 8'h00;
    n_cmp += 3;
    if (j !== 8'h00 || k !== 8'h00) begin n_bad++; $display("FAIL mid_jk: j=%h k=%h required 00 00", j, k); end
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL mid_flags: ready=%b done=%b required 1 0", req_ready, done);
    end
    if (expected !== 8'h00 || err_count !== 8'h00) begin
      n_bad++; $display("FAIL mid_state: expected=%h err=%0d required 00 0", expected, err_count);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++; $display("FAIL mid_no_done: done=%b ready=%b required 0 1", done, req_ready);
    end
  endtask

  task automatic test_rst_with_valid;
    rst = 1'b1; req_valid = 1'b1; req_op = 2'd0; req_data = 8'h5A;
    step();
    rst = 1'b0; req_valid = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b1 || j !== 8'h00) begin
      n_bad++; $display("FAIL rst_valid: ready=%b j=%h required 1 00", req_ready, j);
    end
    do_req(2'd0, 8'h5A);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_directed();
    test_zero_mask();
    test_stuck();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset_mid_drive();
    test_rst_with_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_excite_driver.md
Name: jk_excite_driver

Overview:
- Controller for the other side of a bank of JK flip-flops: turns register-level requests into per-bit J/K excitation vectors.
- Accepts LOAD/SET/CLR/TOGGLE requests over a valid/ready handshake.
- Drives j/k for exactly one cycle, keeps a mirror of the expected flop state, and checks the bank's q feedback against it.
- Sits between a control sequencer and a WIDTH-bit array of JK flops.

Parameters:
- WIDTH, 8, number of JK flops driven; also the width of data, mirror and feedback.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_op  in  2  00 LOAD, 01 SET, 10 CLR, 11 TOG.
- req_data  in  WIDTH  operand (value for LOAD, bit mask for SET/CLR/TOG).
- j  out  WIDTH  J excitation to the flop bank.
- k  out  WIDTH  K excitation to the flop bank.
- q_fb  in  WIDTH  q outputs of the flop bank.
- expected  out  WIDTH  mirror of the intended bank state.
- done  out  1  one-cycle pulse when a request completes.
- mismatch  out  1  one-cycle pulse, coincident with done, when q_fb != expected.
- err_count  out  ERR_W  count of mismatches; saturates.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values:
  - state = IDLE, j = k = 0, expected = 0, done = 0, mismatch = 0, err_count = 0.
  - req_ready = 1 in the first cycle after reset.
- FSM: IDLE -> DRIVE -> CHECK -> IDLE. One request every 3 cycles.
- IDLE:
  - req_ready = 1.
  - If req_valid is high at a clock edge: latch op and data, compute target from expected, go to DRIVE.
- Target calculation:
  - LOAD: data.
  - SET: expected | data.
  - CLR: expected & ~data.
  - TOG: expected ^ data.
- DRIVE:
  - j and k are registered outputs, valid for exactly this one cycle.
  - Per bit, for LOAD/SET/CLR:
    - 0->1: j=1, k=0.
    - 1->0: j=0, k=1.
    - unchanged: j=0, k=0.
  - TOG: j = k = data (exercises the toggle mode).
  - At the end of DRIVE: expected <= target, go to CHECK.
- CHECK:
  - The bank has sampled j/k at the edge that ends DRIVE, so q_fb now holds the new state.
  - j = k = 0.
  - done = 1.
  - If q_fb != expected:
    - mismatch = 1.
    - err_count increments; it saturates at 2^ERR_W-1.
    - expected resyncs to q_fb at the end of CHECK.
  - Go to IDLE.
- Latency: handshake accepted at edge N -> j/k valid in cycle N+1 -> done/mismatch in cycle N+2 -> req_ready in cycle N+3.
- Outside DRIVE, j and k are always 0, so the bank holds its state.
- req_valid while not in IDLE is ignored. Requests are never queued. The requester must hold req_valid until req_ready.
- Reset in any state, including mid-DRIVE:
  - Next cycle is IDLE with all reset values.
  - The in-flight request is dropped; no done pulse.
- rst and req_valid in the same cycle: rst wins, request not accepted.
- Mask of 0 for SET/CLR/TOG: j = k = 0, still completes with done.

Decomposition:
- Package jk_pkg:
  - op encodings OP_LOAD/OP_SET/OP_CLR/OP_TOG.
  - FSM state enum {IDLE, DRIVE, CHECK}.
  - Width constants.
- Sub-module jk_excite: purely combinational, WIDTH-parameterised.
  - Inputs: cur, tgt, tog_mode, mask.
  - Outputs: j, k.
  - Holds the excitation-table logic; jk_excite_driver registers its outputs into j/k.

Test Plan:
- Common setup: WIDTH=8, bank of 8 jkff instances with rst_n = ~rst.
- Reset: assert rst for 2 cycles -> req_ready=1, j=k=0x00, expected=0x00, err_count=0, done=0.
- LOAD 0xA5 from reset -> DRIVE cycle j=0xA5, k=0x00; next cycle q_fb=0xA5, done=1, mismatch=0, expected=0xA5.
- SET 0x0F, then CLR 0x81 -> first j=0x0A k=0x00 (expected 0xAF), then j=0x00 k=0x81 (expected 0x2E); both done without mismatch.
- TOG 0xFF from 0x2E -> j=k=0xFF for one cycle, q_fb=0xD1, expected=0xD1, mismatch=0.
- Force bank bit0 stuck at 0, LOAD 0x01 -> CHECK shows done=1, mismatch=1, err_count=1; expected=0x00 afterwards.
- Hold req_valid high continuously -> accepts only every 3rd cycle.
- Assert rst during DRIVE -> next cycle j=k=0, req_ready=1, expected=0, no done pulse.
